// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a single-port data memory: load, store and
// block copy requests sequenced one memory access per cycle, one response pulse each.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_data,
  input  logic [4:0]  req_len,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  // Handshake: a request is taken at a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. Responses are single-cycle pulses with no backpressure.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STORE = 3'd2,
    S_CP_RD = 3'd3,
    S_CP_WR = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_addr;       // load/store address, copy source
  logic [15:0] r_data;       // store data, copy destination
  logic [4:0]  r_count;
  logic [4:0]  r_copied;
  logic [15:0] r_buf;
  logic [15:0] r_resp_data;
  logic        r_resp_err;
  logic        w_fire;

  assign w_fire = req_valid && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Memory-side outputs depend on registered state only, never on req_* inputs.
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    mem_we    = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_LOAD:  w_next = S_LOAD;
            OP_STORE: w_next = S_STORE;
            OP_COPY:  w_next = (req_len != 5'd0) ? S_CP_RD : S_RESP;
            default:  w_next = S_RESP;
          endcase
        end
      end
      S_LOAD: begin
        mem_addr = r_addr;
        w_next   = S_RESP;
      end
      S_STORE: begin
        mem_addr  = r_addr;
        mem_wdata = r_data;
        mem_we    = 1'b1;
        w_next    = S_RESP;
      end
      S_CP_RD: begin
        mem_addr = r_addr;
        w_next   = S_CP_WR;
      end
      S_CP_WR: begin
        mem_addr  = r_data;
        mem_wdata = r_buf;
        mem_we    = 1'b1;
        w_next    = (r_count == 5'd1) ? S_RESP : S_CP_RD;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Response registers are written only on the way into RESP, so they hold until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr      <= 16'h0000;
      r_data      <= 16'h0000;
      r_count     <= 5'd0;
      r_copied    <= 5'd0;
      r_buf       <= 16'h0000;
      r_resp_data <= 16'h0000;
      r_resp_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_addr   <= req_addr;
            r_data   <= req_data;
            r_count  <= req_len;
            r_copied <= 5'd0;
            if (req_op == OP_COPY && req_len == 5'd0) begin
              r_resp_data <= 16'h0000;
              r_resp_err  <= 1'b0;
            end else if (req_op == 2'b11) begin
              r_resp_data <= 16'h0000;
              r_resp_err  <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          r_resp_data <= mem_rdata;
          r_resp_err  <= 1'b0;
        end
        S_STORE: begin
          r_resp_data <= 16'h0000;
          r_resp_err  <= 1'b0;
        end
        S_CP_RD: begin
          r_buf <= mem_rdata;
        end
        S_CP_WR: begin
          // Addresses wrap modulo 2^16; ascending order defines overlap behaviour.
          r_addr   <= r_addr + 16'd1;
          r_data   <= r_data + 16'd1;
          r_count  <= r_count - 5'd1;
          r_copied <= r_copied + 5'd1;
          if (r_count == 5'd1) begin
            r_resp_data <= {11'd0, r_copied + 5'd1};
            r_resp_err  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign busy       = (r_state != S_IDLE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: behavioural data memory, directed
// requests, and a response scoreboard checked by an independent monitor.
module tb_mem_access_ctrl;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [4:0]  req_len;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // {response cycle[15:0], err, data[15:0]}
  logic [32:0] exp_q[$];

  logic [15:0] mem [0:65535];

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_len    (req_len),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset / memory ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0x1111,0x1122,0x2222,0x2233,...,0x8888,0x8899 at 0..15; 0x7777 at 0xFFFF
  task automatic preload();
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 65536; i++) mem[i] <= 16'h0000;
    for (int i = 0; i < 16; i++) begin
      a = 8'((i / 2 + 1) * 8'h11);
      b = 8'((i / 2 + 2) * 8'h11);
      mem[i] <= (i % 2 == 0) ? {a, a} : {a, b};
    end
    mem[16'hFFFF] <= 16'h7777;
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] d,
                      input logic [4:0] len, input logic [15:0] ed, input logic ee,
                      input int lat, input bit push, output int h);
    int w;
    w = 0;
    @(negedge clk);
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    req_len   = len;
    req_valid = 1'b1;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL handshake_timeout: got req_ready=0 expected 1 within 200 cycles");
      req_valid = 1'b0;
      h = cyc;
      return;
    end
    h = cyc;
    if (push) exp_q.push_back({16'(h + lat), ee, ed});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    if (reset && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid data 0x%0h err %0d expected none", resp_data, resp_err);
      end else begin
        e = exp_q.pop_front();
        check("resp_data", 32'(resp_data), 32'(e[15:0]));
        check("resp_err", 32'(resp_err), 32'(e[16]));
        check("resp_cycle", 32'(cyc[15:0]), 32'(e[32:17]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int h;
    int h2;
    logic [10:0] busy_v;
    logic [10:0] we_v;
    logic we_seen;

    reset     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 16'h0000;
    req_data  = 16'h0000;
    req_len   = 5'd0;
    preload();
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // load addr 3
    send(2'b00, 16'd3, 16'h0000, 5'd0, 16'h2233, 1'b0, 2, 1'b1, h);
    we_seen = 1'b0;
    @(negedge clk);
    we_seen |= mem_we;
    check("load_mem_addr_c1", 32'(mem_addr), 32'd3);
    @(negedge clk);
    we_seen |= mem_we;
    check("load_ready_c2", 32'(req_ready), 32'd0);
    @(negedge clk);
    we_seen |= mem_we;
    check("load_ready_c3", 32'(req_ready), 32'd1);
    check("load_no_write", 32'(we_seen), 32'd0);

    // store 0xABCD to addr 5, then load it back
    send(2'b01, 16'd5, 16'hABCD, 5'd0, 16'h0000, 1'b0, 2, 1'b1, h);
    @(negedge clk);
    check("store_we_c1", 32'(mem_we), 32'd1);
    check("store_addr_c1", 32'(mem_addr), 32'd5);
    check("store_wdata_c1", 32'(mem_wdata), 32'hABCD);
    @(negedge clk);
    check("store_we_c2", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("store_we_c3", 32'(mem_we), 32'd0);
    send(2'b00, 16'd5, 16'h0000, 5'd0, 16'hABCD, 1'b0, 2, 1'b1, h);
    repeat (3) @(negedge clk);

    // copy src 0 -> dst 8, 4 words
    send(2'b10, 16'd0, 16'd8, 5'd4, 16'd4, 1'b0, 9, 1'b1, h);
    busy_v = '0;
    we_v   = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      busy_v[i] = busy;
      we_v[i]   = mem_we;
    end
    check("copy_busy_cycles", 32'(busy_v), 32'h3FE);
    check("copy_we_cycles", 32'(we_v), 32'h154);
    check("copy_mem8", 32'(mem[8]), 32'h1111);
    check("copy_mem9", 32'(mem[9]), 32'h1122);
    check("copy_mem10", 32'(mem[10]), 32'h2222);
    check("copy_mem11", 32'(mem[11]), 32'h2233);

    // zero-length copy and reserved op
    send(2'b10, 16'd0, 16'd8, 5'd0, 16'h0000, 1'b0, 1, 1'b1, h);
    @(negedge clk);
    check("len0_we", 32'(mem_we), 32'd0);
    check("len0_busy", 32'(busy), 32'd1);
    send(2'b11, 16'd2, 16'd3, 5'd7, 16'h0000, 1'b1, 1, 1'b1, h);
    @(negedge clk);
    check("rsvd_we", 32'(mem_we), 32'd0);
    @(negedge clk);
    check("rsvd_hold_err", 32'(resp_err), 32'd1);

    // reset in cycle 4 of a 4-word copy (fresh memory image)
    preload();
    send(2'b10, 16'd0, 16'd8, 5'd4, 16'h0000, 1'b0, 0, 1'b0, h);
    repeat (4) @(negedge clk);
    check("abort_we_before", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(negedge clk);
    check("abort_mem8", 32'(mem[8]), 32'h1111);
    check("abort_mem9", 32'(mem[9]), 32'h5566);
    check("abort_mem10", 32'(mem[10]), 32'h6666);
    check("abort_mem11", 32'(mem[11]), 32'h6677);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    send(2'b00, 16'd8, 16'h0000, 5'd0, 16'h1111, 1'b0, 2, 1'b1, h);
    repeat (3) @(negedge clk);

    // address wrap: src 0xFFFF, 0x0000 -> dst 0x30, 0x31
    send(2'b10, 16'hFFFF, 16'h0030, 5'd2, 16'd2, 1'b0, 5, 1'b1, h);
    repeat (6) @(negedge clk);
    check("wrap_mem30", 32'(mem[16'h0030]), 32'h7777);
    check("wrap_mem31", 32'(mem[16'h0031]), 32'h1111);

    // request held during a copy is ignored until the first IDLE cycle
    send(2'b10, 16'd0, 16'd20, 5'd2, 16'd2, 1'b0, 5, 1'b1, h);
    send(2'b00, 16'd3, 16'h0000, 5'd0, 16'h2233, 1'b0, 2, 1'b1, h2);
    check("b2b_accept_cycle", 32'(h2 - h), 32'd6);
    check("b2b_mem20", 32'(mem[20]), 32'h1111);
    check("b2b_mem21", 32'(mem[21]), 32'h1122);

    begin
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (exp_q.size() != 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL resp_timeout: got %0d pending responses expected 0", exp_q.size());
      end
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
